// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//   Single-issue integer execute stage.  Operations are decoded and evaluated
//   on acceptance, and their results are queued in a 2-entry output FIFO.
//   Shift operations take one of two paths:
//     - default build          : single-cycle barrel shifter, latency 1
//     - ALU_EXEC_STAGE_SERIAL_SHIFT_EN defined : one bit per cycle through an
//       IDLE -> SHIFT -> IDLE FSM (shift by 0 still completes in one cycle)
//
// Parameters
//   XLEN : datapath width (32 or 64)
//   TAGW : sideband tag width
//
// Ports
//   CLK, RST_N                    clock (rising edge), async active-low reset
//   in_valid / in_ready           operation handshake
//   in_fn, in_op1, in_op2, in_tag operation code, operands, sideband tag
//   out_valid / out_ready         result handshake (FIFO head)
//   out_result, out_tag           head result and its tag
//   out_zero, out_illegal         head result == 0, head fn was unsupported
//   busy                          serial shift in progress
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high.  A producer holding valid must keep its payload stable until ready;
// ready never depends combinationally on the same side's valid.
// -----------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int XLEN = 32,
    parameter int TAGW = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_fn,
    input  logic [XLEN-1:0] in_op1,
    input  logic [XLEN-1:0] in_op2,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [TAGW-1:0] out_tag,
    output logic            out_zero,
    output logic            out_illegal,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SLL  = 4'd1;
    localparam logic [3:0] FN_SLT  = 4'd2;
    localparam logic [3:0] FN_SLTU = 4'd3;
    localparam logic [3:0] FN_XOR  = 4'd4;
    localparam logic [3:0] FN_SRL  = 4'd5;
    localparam logic [3:0] FN_OR   = 4'd6;
    localparam logic [3:0] FN_AND  = 4'd7;
    localparam logic [3:0] FN_SUB  = 4'd8;
    localparam logic [3:0] FN_SRA  = 4'd13;

    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
    state_t state_q, state_d;

    // FIFO storage and pointers
    logic [XLEN-1:0] res_mem  [2];
    logic [TAGW-1:0] tag_mem  [2];
    logic            zero_mem [2];
    logic            ill_mem  [2];
    logic [1:0]      count_q;
    logic            rd_ptr_q, wr_ptr_q;

    logic            accept, push, pop;
    logic [XLEN-1:0] push_res;
    logic [TAGW-1:0] push_tag;
    logic            push_ill;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;

    // Gated with RST_N so nothing is offered while reset is held.
    assign in_ready  = RST_N && (count_q < 2'd2) && (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign busy      = (state_q == ST_SHIFT);

    assign shamt = in_op2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (in_fn)
            FN_ADD:  alu_res = in_op1 + in_op2;
            FN_SUB:  alu_res = in_op1 - in_op2;
            FN_SLL:  alu_res = in_op1 << shamt;
            FN_SRL:  alu_res = in_op1 >> shamt;
            FN_SRA:  alu_res = $unsigned($signed(in_op1) >>> shamt);
            FN_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_op1) < $signed(in_op2))};
            FN_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_op1 < in_op2)};
            FN_XOR:  alu_res = in_op1 ^ in_op2;
            FN_OR:   alu_res = in_op1 | in_op2;
            FN_AND:  alu_res = in_op1 & in_op2;
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_STAGE_SERIAL_SHIFT_EN
    localparam logic [SHW-1:0] SH_ONE = {{(SHW-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] sh_val_q, sh_next;
    logic [SHW-1:0]  sh_cnt_q;
    logic [1:0]      sh_kind_q;   // 0 SLL, 1 SRL, 2 SRA
    logic [TAGW-1:0] sh_tag_q;
    logic            is_shift, start_shift, shift_done;

    assign is_shift    = (in_fn == FN_SLL) || (in_fn == FN_SRL) || (in_fn == FN_SRA);
    // Shift by zero has nothing to iterate and goes down the normal path.
    assign start_shift = accept && is_shift && (shamt != '0);
    // The last single-bit step is taken and pushed on the same edge.
    assign shift_done  = (state_q == ST_SHIFT) && (sh_cnt_q == SH_ONE);

    always_comb begin
        sh_next = sh_val_q;
        case (sh_kind_q)
            2'd0:    sh_next = {sh_val_q[XLEN-2:0], 1'b0};
            2'd1:    sh_next = {1'b0, sh_val_q[XLEN-1:1]};
            default: sh_next = {sh_val_q[XLEN-1], sh_val_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_shift) state_d = ST_SHIFT;
            ST_SHIFT: if (shift_done)  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sh_val_q  <= '0;
            sh_cnt_q  <= '0;
            sh_kind_q <= 2'd0;
            sh_tag_q  <= '0;
        end else if (start_shift) begin
            sh_val_q  <= in_op1;
            sh_cnt_q  <= shamt;
            sh_kind_q <= (in_fn == FN_SLL) ? 2'd0 : (in_fn == FN_SRL) ? 2'd1 : 2'd2;
            sh_tag_q  <= in_tag;
        end else if (state_q == ST_SHIFT) begin
            sh_val_q  <= sh_next;
            sh_cnt_q  <= sh_cnt_q - SH_ONE;
        end
    end

    // accept and shift_done are exclusive: in_ready is low during SHIFT.
    assign push     = (accept && !start_shift) || shift_done;
    assign push_res = shift_done ? sh_next  : alu_res;
    assign push_tag = shift_done ? sh_tag_q : in_tag;
    assign push_ill = shift_done ? 1'b0     : alu_ill;
`else
    always_comb begin
        state_d = ST_IDLE;
    end

    assign push     = accept;
    assign push_res = alu_res;
    assign push_tag = in_tag;
    assign push_ill = alu_ill;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Storage is cleared on reset so the head reads as all-zero while reset
    // is held.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                res_mem[i]  <= '0;
                tag_mem[i]  <= '0;
                zero_mem[i] <= 1'b0;
                ill_mem[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                res_mem[wr_ptr_q]  <= push_res;
                tag_mem[wr_ptr_q]  <= push_tag;
                zero_mem[wr_ptr_q] <= (push_res == '0);
                ill_mem[wr_ptr_q]  <= push_ill;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign out_result  = res_mem[rd_ptr_q];
    assign out_tag     = tag_mem[rd_ptr_q];
    assign out_zero    = zero_mem[rd_ptr_q];
    assign out_illegal = ill_mem[rd_ptr_q];

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
//   Self-checking bench for alu_exec_stage.  A 32-bit instance carries the main
//   traffic; a 64-bit instance covers the wide shift-amount case.
//   Expected results are queued when an operation is accepted and compared
//   when the DUT hands them out.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;
  localparam int EW = 38;  // {illegal, zero, tag[3:0], result[31:0]}

`ifdef ALU_EXEC_STAGE_SERIAL_SHIFT_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- 32-bit DUT ----------------
  logic        in_valid, in_ready;
  logic [3:0]  in_fn;
  logic [31:0] in_op1, in_op2;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        out_zero, out_illegal, busy;
  logic        out_ready_man, rand_bp, bp_rand;

  assign out_ready = rand_bp ? bp_rand : out_ready_man;

  alu_exec_stage #(.XLEN(32), .TAGW(4)) dut (
    .CLK(clk), .RST_N(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_fn(in_fn),
    .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_zero(out_zero), .out_illegal(out_illegal),
    .busy(busy)
  );

  // ---------------- 64-bit DUT ----------------
  logic        w_in_valid, w_in_ready;
  logic [3:0]  w_in_fn;
  logic [63:0] w_in_op1, w_in_op2;
  logic [3:0]  w_in_tag;
  logic        w_out_valid, w_out_ready;
  logic [63:0] w_out_result;
  logic [3:0]  w_out_tag;
  logic        w_out_zero, w_out_illegal, w_busy;

  alu_exec_stage #(.XLEN(64), .TAGW(4)) dut64 (
    .CLK(clk), .RST_N(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_fn(w_in_fn),
    .in_op1(w_in_op1), .in_op2(w_in_op2), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_result(w_out_result),
    .out_tag(w_out_tag), .out_zero(w_out_zero), .out_illegal(w_out_illegal),
    .busy(w_busy)
  );

  always @(posedge clk) begin
    #1 bp_rand = ($urandom_range(0, 3) != 0);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [31:0] res, input logic ill,
                                         input logic [3:0] tag);
    return {ill, (res == 32'd0), tag, res};
  endfunction

  // Reference ALU: shifts are iterated bit by bit, signed compare by sign bits.
  function automatic logic [EW-1:0] model(input logic [3:0] fn, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] tag);
    logic [31:0] r;
    logic        ill;
    int          sh;
    r   = 32'd0;
    ill = 1'b0;
    sh  = int'(b[4:0]);
    case (fn)
      4'd0:  r = a + b;
      4'd8:  r = a + ~b + 32'd1;
      4'd2:  r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'd3:  r = {31'd0, (a < b)};
      4'd4:  r = a ^ b;
      4'd6:  r = a | b;
      4'd7:  r = a & b;
      4'd1:  begin r = a; for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0}; end
      4'd5:  begin r = a; for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]}; end
      4'd13: begin r = a; for (int i = 0; i < sh; i++) r = {r[31], r[31:1]}; end
      default: ill = 1'b1;
    endcase
    return pack(r, ill, tag);
  endfunction

  // Scoreboard: compare every result the consumer takes.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got tag %h result %h with nothing pending", out_tag, out_result);
      end else begin
        e = exp_q.pop_front();
        check("result",  {32'd0, out_result},  {32'd0, e[31:0]});
        check("tag",     {60'd0, out_tag},     {60'd0, e[35:32]});
        check("zero",    {63'd0, out_zero},    {63'd0, e[36]});
        check("illegal", {63'd0, out_illegal}, {63'd0, e[37]});
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [EW-1:0] exp);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_fn    = fn;
    in_op1   = a;
    in_op2   = b;
    in_tag   = tag;
    for (int guard = 0; guard < 100 && !done; guard++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        exp_q.push_back(exp);
        done = 1'b1;
      end else begin
        @(posedge clk);
      end
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: tag %h never accepted", tag);
    end
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int guard = 0; guard < 400 && !empty; guard++) begin
      @(negedge clk);
      empty = (exp_q.size() == 0) && !out_valid;
    end
    n_checks++;
    if (!empty) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [3:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  vec_t vecs[16];
  int   lat;
  logic [3:0]  rfn;
  logic [31:0] ra, rb;
  logic [3:0]  legal_fns[10];
  bit          seen;

  initial begin
    vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[1]  = '{4'd8,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{4'd2,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[3]  = '{4'd3,  32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[4]  = '{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
    vecs[5]  = '{4'd6,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
    vecs[6]  = '{4'd7,  32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, 1'b0};
    vecs[7]  = '{4'd1,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0};
    vecs[8]  = '{4'd5,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0};
    vecs[9]  = '{4'd13, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0};
    vecs[10] = '{4'd2,  32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{4'd3,  32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 1'b0};
    vecs[12] = '{4'd9,  32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[13] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[14] = '{4'd0,  32'h0000_0007, 32'h0000_0008, 32'h0000_000F, 1'b0};
    vecs[15] = '{4'd5,  32'hA5A5_A5A5, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
    legal_fns = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13};

    in_valid = 1'b0; in_fn = 4'd0; in_op1 = '0; in_op2 = '0; in_tag = '0;
    out_ready_man = 1'b1; rand_bp = 1'b0; bp_rand = 1'b1;
    w_in_valid = 1'b0; w_in_fn = 4'd0; w_in_op1 = '0; w_in_op2 = '0; w_in_tag = '0;
    w_out_ready = 1'b1;

    // ---- reset state ----
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",    {63'd0, in_ready},    64'd0);
    check("rst_out_valid",   {63'd0, out_valid},   64'd0);
    check("rst_out_result",  {32'd0, out_result},  64'd0);
    check("rst_out_tag",     {60'd0, out_tag},     64'd0);
    check("rst_out_zero",    {63'd0, out_zero},    64'd0);
    check("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
    check("rst_busy",        {63'd0, busy},        64'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // ---- table of directed vectors ----
    for (int i = 0; i < 16; i++)
      send(vecs[i].fn, vecs[i].a, vecs[i].b, 4'(i), pack(vecs[i].res, vecs[i].ill, 4'(i)));
    drain();

    // ---- latency of SRA by 5 and by 0 ----
    for (int s = 0; s < 2; s++) begin
      lat = (SERIAL && s == 0) ? 5 : 0;
      send(4'd13, 32'h8000_0000, (s == 0) ? 32'd5 : 32'd0, 4'hA,
           pack((s == 0) ? 32'hFC00_0000 : 32'h8000_0000, 1'b0, 4'hA));
      for (int k = 1; k <= lat + 1; k++) begin
        @(negedge clk);
        if (k <= lat) begin
          check("shift_busy",      {63'd0, busy},      64'd1);
          check("shift_in_ready",  {63'd0, in_ready},  64'd0);
          check("shift_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          check("done_out_valid", {63'd0, out_valid}, 64'd1);
          check("done_busy",      {63'd0, busy},      64'd0);
        end
      end
      @(posedge clk);
      #1;
      drain();
    end

    // ---- backpressure: tags 1,2 fill the FIFO, tag 3 waits ----
    out_ready_man = 1'b0;
    send(4'd0, 32'd1, 32'd1, 4'd1, pack(32'd2, 1'b0, 4'd1));
    send(4'd0, 32'd2, 32'd2, 4'd2, pack(32'd4, 1'b0, 4'd2));
    in_valid = 1'b1; in_fn = 4'd0; in_op1 = 32'd3; in_op2 = 32'd3; in_tag = 4'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready",  {63'd0, in_ready},   64'd0);
      check("bp_out_valid", {63'd0, out_valid},  64'd1);
      check("bp_hold_tag",  {60'd0, out_tag},    64'd1);
      check("bp_hold_res",  {32'd0, out_result}, 64'd2);
      @(posedge clk);
      #1;
    end
    out_ready_man = 1'b1;
    send(4'd0, 32'd3, 32'd3, 4'd3, pack(32'd6, 1'b0, 4'd3));
    drain();

    // ---- simultaneous push and pop with one entry held ----
    out_ready_man = 1'b0;
    send(4'd4, 32'h55, 32'h0F, 4'd5, pack(32'h5A, 1'b0, 4'd5));
    out_ready_man = 1'b1;
    in_valid = 1'b1; in_fn = 4'd6; in_op1 = 32'h100; in_op2 = 32'h1; in_tag = 4'd6;
    @(negedge clk);
    check("pp_in_ready",  {63'd0, in_ready},  64'd1);
    check("pp_out_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    exp_q.push_back(pack(32'h101, 1'b0, 4'd6));
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("pp_count1_valid", {63'd0, out_valid}, 64'd1);
    check("pp_new_head_tag", {60'd0, out_tag},   64'd6);
    @(negedge clk);
    check("pp_empty_after", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;

    // ---- random traffic under random backpressure ----
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rfn = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : legal_fns[$urandom_range(0, 9)];
      if (rfn == 4'd13) rfn = 4'd10;
      ra = $urandom();
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom();
      send(rfn, ra, rb, 4'(i), model(rfn, ra, rb, 4'(i)));
    end
    rand_bp = 1'b0;
    drain();

    // ---- reset mid-stream discards queued results ----
    out_ready_man = 1'b0;
    send(4'd0, 32'd10, 32'd1, 4'd7, pack(32'd11, 1'b0, 4'd7));
    send(4'd0, 32'd20, 32'd2, 4'd8, pack(32'd22, 1'b0, 4'd8));
`ifdef ALU_EXEC_STAGE_SERIAL_SHIFT_EN
    out_ready_man = 1'b1;
    drain();
    send(4'd5, 32'hFFFF_0000, 32'd10, 4'd9, pack(32'h003F_FFC0, 1'b0, 4'd9));
    repeat (3) @(posedge clk);
    #1;
`endif
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_busy",      {63'd0, busy},      64'd0);
    check("mid_rst_in_ready",  {63'd0, in_ready},  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_man = 1'b1;
    #1;
    check("mid_rst_release_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_output", {63'd0, seen}, 64'd0);
    @(posedge clk);
    #1;

    // ---- 64-bit instance: shift amount uses op2[5:0] only ----
    w_in_valid = 1'b1; w_in_fn = 4'd1; w_in_op1 = 64'd1; w_in_op2 = 64'h7F; w_in_tag = 4'hC;
    @(negedge clk);
    check("w_in_ready", {63'd0, w_in_ready}, 64'd1);
    @(posedge clk);
    #1 w_in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = w_out_valid;
    end
    check("w_out_valid",  {63'd0, seen},          64'd1);
    check("w_result",     w_out_result,           64'h8000_0000_0000_0000);
    check("w_tag",        {60'd0, w_out_tag},     64'hC);
    check("w_zero",       {63'd0, w_out_zero},    64'd0);
    check("w_illegal",    {63'd0, w_out_illegal}, 64'd0);
    @(posedge clk);
    #1;
    w_in_valid = 1'b1; w_in_fn = 4'd9; w_in_op1 = 64'hFFFF; w_in_op2 = 64'd3; w_in_tag = 4'hD;
    @(posedge clk);
    #1 w_in_valid = 1'b0;
    @(negedge clk);
    check("w_ill_valid",   {63'd0, w_out_valid},   64'd1);
    check("w_ill_result",  w_out_result,           64'd0);
    check("w_ill_illegal", {63'd0, w_out_illegal}, 64'd1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter TAGW, default 4, width of the sideband tag carried with each operation.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation offered.
REQ-006 SHALL have port in_ready  output  1  operation accepted this cycle if in_valid.
REQ-007 SHALL have port in_fn  input  4  operation code.
REQ-008 SHALL have ports in_op1, in_op2  input  XLEN  operands.
REQ-009 SHALL have port in_tag  input  TAGW  sideband tag.
REQ-010 SHALL have port out_valid  output  1  result available at FIFO head.
REQ-011 SHALL have port out_ready  input  1  consumer takes head this cycle if out_valid.
REQ-012 SHALL have ports out_result  output  XLEN, out_tag  output  TAGW, out_zero  output  1 (result == 0), out_illegal  output  1 (unsupported in_fn).
REQ-013 SHALL have port busy  output  1  high while a serial shift is in progress.

Function
REQ-014 SHALL accept an operation when in_valid && in_ready; in_ready = (fifo count < 2) && (state == IDLE).
REQ-015 SHALL decode in_fn: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND, 8 SUB, 13 SRA; all other codes give result 0 and out_illegal = 1.
REQ-016 SHALL perform ADD/SUB modulo 2^XLEN, discard carry; SLT signed and SLTU unsigned compares give 1 or 0 zero-extended to XLEN.
REQ-017 SHALL take shift amount from in_op2[log2(XLEN)-1:0], ignoring the upper bits; SRA replicates op1 MSB.
REQ-018 SHALL store results (result, tag, zero, illegal) in a 2-entry FIFO; out_* present the head entry, and their values are don't-care when out_valid = 0.
REQ-019 SHALL, for non-serial operations, push the result on the acceptance edge, so out_valid is high the cycle after acceptance (latency 1).
REQ-020 SHALL, on a simultaneous push and pop, keep count unchanged and preserve entry order.
REQ-021 SHALL, on a pop with count 0, do nothing; a push with count 2 cannot occur because in_ready is low.
REQ-022 SHALL hold out_* stable while out_valid && !out_ready.

Reset
REQ-023 SHALL, on RST_N low, asynchronously clear the FIFO (count 0), set state IDLE, and clear the shift counter.
REQ-024 SHALL drive in_ready 0 during reset, and 1 in the first cycle after reset release.
REQ-025 SHALL drive out_valid 0, out_result 0, out_tag 0, out_zero 0, out_illegal 0 and busy 0 during reset.
REQ-026 SHALL discard, with no output produced, any operation in flight (including a partial serial shift) when reset asserts.

Configuration
REQ-027 SHALL implement macro ALU_EXEC_STAGE_SERIAL_SHIFT_EN; when undefined, SLL/SRL/SRA use a single-cycle barrel shifter (REQ-019 latency).
REQ-028 SHALL, with the macro defined, run SLL/SRL/SRA through FSM IDLE -> SHIFT -> IDLE, shifting one bit per cycle.
REQ-029 SHALL, with the macro defined and shamt = 0, complete as a normal latency-1 operation with no SHIFT state.
REQ-030 SHALL, with the macro defined and shamt = n > 0, stay in SHIFT for n cycles with busy = 1 and in_ready = 0, push on the final shift edge, and give out_valid n+1 cycles after acceptance.
REQ-031 SHALL rely on REQ-014 to guarantee FIFO room at serial-shift completion; pops during SHIFT remain allowed.

Verification
REQ-032 Reset mid-stream: push 2 ADDs, assert RST_N low -> out_valid 0, count 0, in_ready 1 after release.
REQ-033 Arithmetic: XLEN=32, ADD 0xFFFFFFFF+1 -> result 0, out_zero 1; SUB 0-1 -> 0xFFFFFFFF; SLT 0x80000000,1 -> 1; SLTU same operands -> 0.
REQ-034 Backpressure: out_ready 0, offer 3 ops (tags 1,2,3) -> tags 1,2 accepted, in_ready 0 until one pop; raise out_ready -> tags out in order 1,2,3.
REQ-035 Concurrent push/pop: count 1, simultaneous accept and pop -> count stays 1, next head is the new tag.
REQ-036 Serial shift (macro on): SRA 0x80000000 by 5 -> busy high for 5 cycles, out_valid at cycle 6, result 0xFC000000; same op by 0 -> latency 1.
REQ-037 Illegal/XLEN=64: in_fn 9 -> result 0, out_illegal 1; XLEN=64 SLL 1 by op2 = 0x7F -> shift by 63, result 0x8000000000000000.
